// File: rtl/ndc_to_screen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ndc_to_screen                                                   |
// | Purpose  : Perspective divide (x/z, y/z) with two lockstep restoring       |
// |            dividers, mapping to integer pixel coordinates, near-plane      |
// |            culling and off-screen flagging behind a valid/ready handshake. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ndc_to_screen #(
  parameter int DOT_WIDTH = 23,
  parameter int FRAC_BITS = 14,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 180,
  parameter int PX_WIDTH  = 9,
  parameter int Z_NEAR    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic signed [DOT_WIDTH-1:0] x_in,
  input  logic signed [DOT_WIDTH-1:0] y_in,
  input  logic signed [DOT_WIDTH-1:0] z_in,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic        [PX_WIDTH-1:0]  px,
  output logic        [PX_WIDTH-1:0]  py,
  output logic signed [DOT_WIDTH-1:0] z_out,
  output logic                        culled,
  output logic                        offscreen
);

  localparam int ONE  = 1 << FRAC_BITS;
  // Quotient magnitude bits: one integer bit plus the fraction.
  localparam int QW   = FRAC_BITS + 1;
  localparam int SQW  = FRAC_BITS + 2;
  // Remainder is kept below 2*z, so one bit wider than the operands.
  localparam int RW   = DOT_WIDTH + 1;
  localparam int CW   = $clog2(FRAC_BITS + 2);
  localparam int SMAX = (SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H;
  // (q + ONE) spans under 3*ONE in magnitude; times the screen size plus sign.
  localparam int MW   = FRAC_BITS + 4 + $clog2(SMAX + 1);
  localparam logic signed [DOT_WIDTH-1:0] ZNEAR_C = DOT_WIDTH'(Z_NEAR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                      state_q;
  logic                        ready_q;
  logic                        valid_q;
  logic        [PX_WIDTH-1:0]  px_q;
  logic        [PX_WIDTH-1:0]  py_q;
  logic signed [DOT_WIDTH-1:0] zout_q;
  logic                        culled_q;
  logic                        off_q;

  logic [DOT_WIDTH-1:0] ax_q;
  logic [DOT_WIDTH-1:0] ay_q;
  logic [DOT_WIDTH-1:0] zd_q;
  logic                 negx_q;
  logic                 negy_q;
  logic                 satx_q;
  logic                 saty_q;
  logic [RW-1:0]        remx_q;
  logic [RW-1:0]        remy_q;
  logic [QW-1:0]        qmx_q;
  logic [QW-1:0]        qmy_q;
  logic signed [SQW-1:0] qx_q;
  logic signed [SQW-1:0] qy_q;
  logic [CW-1:0]        cnt_q;

  logic [DOT_WIDTH-1:0] absx_d;
  logic [DOT_WIDTH-1:0] absy_d;
  logic [DOT_WIDTH-1:0] zu_d;
  logic                 near_d;
  logic                 satx_d;
  logic                 saty_d;
  logic [RW-1:0]        zdiv_d;
  logic                 gex_d;
  logic                 gey_d;
  logic [RW-1:0]        rsx_d;
  logic [RW-1:0]        rsy_d;
  logic [RW-1:0]        remx_d;
  logic [RW-1:0]        remy_d;
  logic [QW-1:0]        qmx_d;
  logic [QW-1:0]        qmy_d;
  logic [QW-1:0]        magx_d;
  logic [QW-1:0]        magy_d;
  logic signed [SQW-1:0] qxf_d;
  logic signed [SQW-1:0] qyf_d;
  logic signed [MW-1:0] prodx_d;
  logic signed [MW-1:0] prody_d;
  logic signed [MW-1:0] shx_d;
  logic signed [MW-1:0] shy_d;
  logic [PX_WIDTH-1:0]  px_d;
  logic [PX_WIDTH-1:0]  py_d;
  logic                 off_d;

  // Operand magnitudes, divider step, sign restore and screen mapping.
  always_comb begin
    absx_d = x_in;
    if (x_in[DOT_WIDTH-1]) absx_d = ~x_in + DOT_WIDTH'(1);
    absy_d = y_in;
    if (y_in[DOT_WIDTH-1]) absy_d = ~y_in + DOT_WIDTH'(1);
    zu_d   = z_in;
    near_d = (z_in <= ZNEAR_C);
    // |n| >= 2z would need a second integer quotient bit: saturate instead.
    satx_d = {1'b0, absx_d} >= {zu_d, 1'b0};
    saty_d = {1'b0, absy_d} >= {zu_d, 1'b0};

    zdiv_d = {1'b0, zd_q};
    gex_d  = (remx_q >= zdiv_d);
    gey_d  = (remy_q >= zdiv_d);
    rsx_d  = gex_d ? (remx_q - zdiv_d) : remx_q;
    rsy_d  = gey_d ? (remy_q - zdiv_d) : remy_q;
    remx_d = rsx_d << 1;
    remy_d = rsy_d << 1;
    qmx_d  = {qmx_q[QW-2:0], gex_d};
    qmy_d  = {qmy_q[QW-2:0], gey_d};

    magx_d = satx_q ? {QW{1'b1}} : qmx_q;
    magy_d = saty_q ? {QW{1'b1}} : qmy_q;
    qxf_d  = negx_q ? -$signed({1'b0, magx_d}) : $signed({1'b0, magx_d});
    qyf_d  = negy_q ? -$signed({1'b0, magy_d}) : $signed({1'b0, magy_d});

    prodx_d = (MW'(qx_q) + MW'(ONE)) * MW'(SCREEN_W);
    prody_d = (MW'(ONE) - MW'(qy_q)) * MW'(SCREEN_H);
    shx_d   = prodx_d >>> (FRAC_BITS + 1);
    shy_d   = prody_d >>> (FRAC_BITS + 1);

    if (prodx_d[MW-1])                    px_d = '0;
    else if (shx_d > MW'(SCREEN_W - 1))   px_d = PX_WIDTH'(SCREEN_W - 1);
    else                                  px_d = shx_d[PX_WIDTH-1:0];

    if (prody_d[MW-1])                    py_d = '0;
    else if (shy_d > MW'(SCREEN_H - 1))   py_d = PX_WIDTH'(SCREEN_H - 1);
    else                                  py_d = shy_d[PX_WIDTH-1:0];

    // Strict compare: a point exactly on the frustum edge stays on-screen.
    off_d = (ax_q > zd_q) || (ay_q > zd_q);
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      zout_q   <= '0;
      culled_q <= 1'b0;
      off_q    <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      zd_q     <= '0;
      negx_q   <= 1'b0;
      negy_q   <= 1'b0;
      satx_q   <= 1'b0;
      saty_q   <= 1'b0;
      remx_q   <= '0;
      remy_q   <= '0;
      qmx_q    <= '0;
      qmy_q    <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in && ready_q) begin
            ready_q <= 1'b0;
            ax_q    <= absx_d;
            ay_q    <= absy_d;
            zd_q    <= zu_d;
            if (near_d) begin
              state_q  <= S_OUT;
              valid_q  <= 1'b1;
              culled_q <= 1'b1;
              off_q    <= 1'b0;
              px_q     <= '0;
              py_q     <= '0;
              zout_q   <= z_in;
            end else begin
              state_q <= S_DIV;
              negx_q  <= x_in[DOT_WIDTH-1];
              negy_q  <= y_in[DOT_WIDTH-1];
              satx_q  <= satx_d;
              saty_q  <= saty_d;
              remx_q  <= {1'b0, absx_d};
              remy_q  <= {1'b0, absy_d};
              qmx_q   <= '0;
              qmy_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        S_DIV: begin
          // FRAC_BITS+1 quotient iterations, then one cycle to restore sign.
          if (cnt_q == CW'(FRAC_BITS + 1)) begin
            qx_q    <= qxf_d;
            qy_q    <= qyf_d;
            state_q <= S_SCALE;
          end else begin
            remx_q <= remx_d;
            remy_q <= remy_d;
            qmx_q  <= qmx_d;
            qmy_q  <= qmy_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        S_SCALE: begin
          px_q     <= px_d;
          py_q     <= py_d;
          off_q    <= off_d;
          culled_q <= 1'b0;
          zout_q   <= zd_q;
          valid_q  <= 1'b1;
          state_q  <= S_OUT;
        end
        S_OUT: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign px        = px_q;
  assign py        = py_q;
  assign z_out     = zout_q;
  assign culled    = culled_q;
  assign offscreen = off_q;

endmodule
`default_nettype wire
